// File: rtl/button_event_scheduler.sv
// Push-button front end: 2-flop sync, tick-sampled debounce, pending-event latch and a
// round-robin valid/ready event port. Define BTN_RELEASE_EVT_EN to also report releases.
module button_event_scheduler #(
    parameter int N_BTN    = 4,
    parameter int TICK_DIV = 16,
    parameter int DB_DEPTH = 3
) (
    input  logic                     cclk,
    input  logic                     clr,
    input  logic [N_BTN-1:0]         btn_in,
    input  logic                     evt_ready,
    output logic                     evt_valid,
    output logic [$clog2(N_BTN)-1:0] evt_idx,
    output logic                     evt_release,
    output logic [N_BTN-1:0]         btn_state,
    output logic                     overrun
);
    localparam int IDX_W = $clog2(N_BTN);
    localparam int CNT_W = $clog2(TICK_DIV);

    logic [N_BTN-1:0]    sync1_q, sync2_q;
    logic [CNT_W-1:0]    presc_q, presc_d;
    logic [DB_DEPTH-1:0] shift_q [N_BTN];
    logic [DB_DEPTH-1:0] shift_d [N_BTN];
    logic [N_BTN-1:0]    state_q, state_d, pend_press_q, pend_press_d;
    logic [N_BTN-1:0]    pend_rel_s, req_s, rise_s, gnt_press_oh_s;
    logic [IDX_W-1:0]    rr_q, rr_d, idx_q, idx_d, gnt_idx_s;
    logic [IDX_W:0]      cand_s;
    logic                tick_s, free_s, found_s, gnt_rel_s, press_ovr_s, rel_ovr_s;
    logic                valid_q, valid_d, rel_q, rel_d, ovr_q, ovr_d;

    // Prescaler tick; the new debounced level is taken from the post-shift value
    always_comb begin
        tick_s  = (presc_q == CNT_W'(TICK_DIV - 1));
        presc_d = tick_s ? {CNT_W{1'b0}} : presc_q + CNT_W'(1);
        for (int i = 0; i < N_BTN; i++) begin
            if (tick_s) begin
                shift_d[i] = {shift_q[i][DB_DEPTH-2:0], sync2_q[i]};
            end else begin
                shift_d[i] = shift_q[i];
            end
            if (tick_s && (&shift_d[i])) begin
                state_d[i] = 1'b1;
            end else if (tick_s && !(|shift_d[i])) begin
                state_d[i] = 1'b0;
            end else begin
                state_d[i] = state_q[i];
            end
        end
        rise_s = state_d & ~state_q;
    end

    // Round-robin search starting at rr_q, press bookkeeping and output register next state
    always_comb begin
        req_s     = pend_press_q | pend_rel_s;
        free_s    = !valid_q || evt_ready;
        found_s   = 1'b0;
        gnt_idx_s = {IDX_W{1'b0}};
        cand_s    = {(IDX_W+1){1'b0}};
        for (int k = 0; k < N_BTN; k++) begin
            cand_s    = {1'b0, rr_q} + (IDX_W+1)'(k);
            cand_s    = (cand_s >= (IDX_W+1)'(N_BTN)) ? cand_s - (IDX_W+1)'(N_BTN) : cand_s;
            gnt_idx_s = (!found_s && req_s[cand_s[IDX_W-1:0]]) ? cand_s[IDX_W-1:0] : gnt_idx_s;
            found_s   = found_s | req_s[cand_s[IDX_W-1:0]];
        end
        // Press has priority; a release is only granted when no press is waiting
        gnt_rel_s = pend_rel_s[gnt_idx_s] & ~pend_press_q[gnt_idx_s];
        for (int i = 0; i < N_BTN; i++) begin
            gnt_press_oh_s[i] = free_s && found_s && !gnt_rel_s && (gnt_idx_s == IDX_W'(i));
        end
        press_ovr_s  = |(rise_s & pend_press_q & ~gnt_press_oh_s);
        pend_press_d = (pend_press_q & ~gnt_press_oh_s) | rise_s;
        valid_d = valid_q;
        idx_d   = idx_q;
        rel_d   = rel_q;
        rr_d    = rr_q;
        if (free_s && found_s) begin
            valid_d = 1'b1;
            idx_d   = gnt_idx_s;
            rel_d   = gnt_rel_s;
            rr_d    = (gnt_idx_s == IDX_W'(N_BTN - 1)) ? {IDX_W{1'b0}} : gnt_idx_s + IDX_W'(1);
        end else if (free_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    assign ovr_d = press_ovr_s | rel_ovr_s;

`ifdef BTN_RELEASE_EVT_EN
    logic [N_BTN-1:0] pend_rel_q, pend_rel_d, fall_s, gnt_rel_oh_s;

    // Release pending bits follow the same set/merge/grant rules as presses
    always_comb begin
        fall_s = ~state_d & state_q;
        for (int i = 0; i < N_BTN; i++) begin
            gnt_rel_oh_s[i] = free_s && found_s && gnt_rel_s && (gnt_idx_s == IDX_W'(i));
        end
        rel_ovr_s  = |(fall_s & pend_rel_q & ~gnt_rel_oh_s);
        pend_rel_d = (pend_rel_q & ~gnt_rel_oh_s) | fall_s;
    end

    // Release pending register
    always_ff @(posedge cclk) begin
        if (clr) begin
            pend_rel_q <= {N_BTN{1'b0}};
        end else begin
            pend_rel_q <= pend_rel_d;
        end
    end

    assign pend_rel_s = pend_rel_q;
`else
    assign pend_rel_s = {N_BTN{1'b0}};
    assign rel_ovr_s  = 1'b0;
`endif

    // Main state registers; clr zeroes everything including a held event
    always_ff @(posedge cclk) begin
        if (clr) begin
            sync1_q      <= {N_BTN{1'b0}};
            sync2_q      <= {N_BTN{1'b0}};
            presc_q      <= {CNT_W{1'b0}};
            state_q      <= {N_BTN{1'b0}};
            pend_press_q <= {N_BTN{1'b0}};
            rr_q         <= {IDX_W{1'b0}};
            idx_q        <= {IDX_W{1'b0}};
            valid_q      <= 1'b0;
            rel_q        <= 1'b0;
            ovr_q        <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                shift_q[i] <= {DB_DEPTH{1'b0}};
            end
        end else begin
            sync1_q      <= btn_in;
            sync2_q      <= sync1_q;
            presc_q      <= presc_d;
            state_q      <= state_d;
            pend_press_q <= pend_press_d;
            rr_q         <= rr_d;
            idx_q        <= idx_d;
            valid_q      <= valid_d;
            rel_q        <= rel_d;
            ovr_q        <= ovr_d;
            for (int i = 0; i < N_BTN; i++) begin
                shift_q[i] <= shift_d[i];
            end
        end
    end

    assign evt_valid   = valid_q;
    assign evt_idx     = idx_q;
    assign evt_release = rel_q;
    assign btn_state   = state_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Scoreboard bench for button_event_scheduler: behavioural model pushes expected events,
// a negedge monitor compares every presented event, debounced level and overrun pulse.
module tb_button_event_scheduler;
    localparam int N  = 4;
    localparam int TD = 4;
    localparam int DB = 3;

    logic         cclk = 1'b0;
    logic         clr, evt_ready, evt_valid, evt_release, overrun;
    logic [N-1:0] btn_in, btn_state;
    logic [1:0]   evt_idx;

    button_event_scheduler #(.N_BTN(N), .TICK_DIV(TD), .DB_DEPTH(DB)) dut (
        .cclk(cclk), .clr(clr), .btn_in(btn_in), .evt_ready(evt_ready),
        .evt_valid(evt_valid), .evt_idx(evt_idx), .evt_release(evt_release),
        .btn_state(btn_state), .overrun(overrun)
    );

    always #5 cclk = ~cclk;

    typedef struct packed {
        logic [1:0] idx;
        logic       rel;
    } evt_t;

    evt_t exp_q[$];
    int   checks = 0, errors = 0, hs_cnt = 0, ovr_cnt = 0;
    bit   mon_en = 1'b0;

    // Reference model state: levels, run-lengths of equal samples, pending flags
    logic [N-1:0] m_s1, m_s2, m_state, m_pp, m_pr;
    int           m_cnt, m_rr;
    int           run_len [N];
    logic         run_val [N];
    bit           m_valid, m_ovr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int           g;
        bit           free, rel, ov;
        logic [N-1:0] ns;
        if (clr) begin
            m_s1 = '0; m_s2 = '0; m_state = '0; m_pp = '0; m_pr = '0;
            m_cnt = 0; m_rr = 0; m_valid = 1'b0; m_ovr = 1'b0;
            for (int i = 0; i < N; i++) begin
                run_len[i] = DB;
                run_val[i] = 1'b0;
            end
            exp_q.delete();
        end else begin
            g    = -1;
            rel  = 1'b0;
            ov   = 1'b0;
            free = !m_valid || evt_ready;
            ns   = m_state;
            if (free) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && (m_pp[(m_rr + k) % N] || m_pr[(m_rr + k) % N])) g = (m_rr + k) % N;
                end
            end
            if (m_cnt == TD - 1) begin
                for (int i = 0; i < N; i++) begin
                    if (m_s2[i] == run_val[i]) run_len[i]++;
                    else begin
                        run_val[i] = m_s2[i];
                        run_len[i] = 1;
                    end
                    if (run_len[i] >= DB) ns[i] = run_val[i];
                end
            end
            if (g >= 0) begin
                rel = !m_pp[g];
                if (rel) m_pr[g] = 1'b0;
                else     m_pp[g] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (ns[i] && !m_state[i]) begin
                    if (m_pp[i]) ov = 1'b1;
                    m_pp[i] = 1'b1;
                end
`ifdef BTN_RELEASE_EVT_EN
                if (!ns[i] && m_state[i]) begin
                    if (m_pr[i]) ov = 1'b1;
                    m_pr[i] = 1'b1;
                end
`endif
            end
            if (free) begin
                if (g >= 0) begin
                    m_valid = 1'b1;
                    exp_q.push_back('{idx: 2'(g), rel: rel});
                    m_rr = (g + 1) % N;
                end else begin
                    m_valid = 1'b0;
                end
            end
            m_ovr   = ov;
            m_state = ns;
            m_s2    = m_s1;
            m_s1    = btn_in;
            m_cnt   = (m_cnt == TD - 1) ? 0 : m_cnt + 1;
        end
    endtask

    initial forever begin
        @(posedge cclk);
        model_step();
    end

    // Monitor: compares presented events against the scoreboard head, pops on acceptance
    initial forever begin
        @(negedge cclk);
        if (mon_en) begin
            chk("btn_state", btn_state, m_state);
            chk("overrun", overrun, m_ovr);
            chk("evt_valid", evt_valid, m_valid);
            if (overrun === 1'b1) ovr_cnt++;
            if (evt_valid === 1'b1) begin
                chk("sb_depth", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    chk("evt_idx", evt_idx, exp_q[0].idx);
                    chk("evt_release", evt_release, exp_q[0].rel);
                    if (evt_ready === 1'b1) begin
                        void'(exp_q.pop_front());
                        hs_cnt++;
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge cclk);
        #1;
    endtask

    initial begin
        int base, obase;
        btn_in    = '0;
        evt_ready = 1'b1;
        clr       = 1'b1;
        cyc(3);
        clr    = 1'b0;
        mon_en = 1'b1;
        chk("reset_valid", evt_valid, 0);
        chk("reset_state", btn_state, 0);

        // three simultaneous presses from rr pointer 0
        base   = hs_cnt;
        btn_in = 4'b1101;
        cyc(30);
        chk("p3_events", hs_cnt - base, 3);
        btn_in = 4'b0000;
        cyc(40);

        // single steady press
        base      = hs_cnt;
        btn_in[1] = 1'b1;
        cyc(30);
        chk("p1_events", hs_cnt - base, 1);
        chk("p1_state", btn_state, 4'b0010);

        // two-tick glitch must not debounce
        base      = hs_cnt;
        obase     = ovr_cnt;
        btn_in[0] = 1'b1;
        cyc(8);
        btn_in[0] = 1'b0;
        cyc(30);
        chk("p2_events", hs_cnt - base, 0);
        chk("p2_state0", btn_state[0], 0);
        chk("p2_overrun", ovr_cnt - obase, 0);

        // held event, pending re-press, then merged third press
        btn_in[1] = 1'b0;
        cyc(30);
        evt_ready = 1'b0;
        obase     = ovr_cnt;
        btn_in[1] = 1'b1;
        cyc(30);
        chk("p4_held_valid", evt_valid, 1);
        chk("p4_held_idx", evt_idx, 1);
        btn_in[1] = 1'b0; cyc(30);
        btn_in[1] = 1'b1; cyc(30);
        btn_in[1] = 1'b0; cyc(30);
        btn_in[1] = 1'b1; cyc(30);
        chk("p4_held_idx2", evt_idx, 1);
        base      = hs_cnt;
        evt_ready = 1'b1;
        cyc(20);
`ifdef BTN_RELEASE_EVT_EN
        chk("p4_overruns", ovr_cnt - obase, 2);
        chk("p4_events", hs_cnt - base, 3);
`else
        chk("p4_overruns", ovr_cnt - obase, 1);
        chk("p4_events", hs_cnt - base, 2);
`endif

        // clr while an event is held and two more are pending
        btn_in = 4'b0000;
        cyc(30);
        evt_ready = 1'b0;
        btn_in    = 4'b1101;
        cyc(30);
        chk("p5_pre_valid", evt_valid, 1);
        clr    = 1'b1;
        btn_in = 4'b0000;
        cyc(1);
        clr = 1'b0;
        chk("p5_valid", evt_valid, 0);
        chk("p5_state", btn_state, 0);
        base      = hs_cnt;
        evt_ready = 1'b1;
        cyc(40);
        chk("p5_events", hs_cnt - base, 0);

        // randomized bouncing buttons, stalls and occasional clr
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                automatic int b = $urandom_range(0, N - 1);
                btn_in[b] = ~btn_in[b];
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        clr       = 1'b0;
        btn_in    = '0;
        evt_ready = 1'b1;
        cyc(60);
        chk("final_valid", evt_valid, 0);
        chk("final_sb", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
